test_check_arbiter: RTL and testbench

Synthesizable self-check engine for on-FPGA regression runs. It arbitrates compare requests from up to NUM_REQ stimulus engines onto a single shared checker, and evaluates each request as either an exact match or an inclusive range check. It keeps a running test count and a fail count, and at end of run raises a sticky pass or fail verdict. A free-running watchdog forces a fail if the run never completes.

---
 rtl/test_check_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_test_check_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_check_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : test_check_arbiter
// Purpose  : Self-check engine for on-FPGA regression runs. Round-robin
//            arbitrates compare requests from NUM_REQ stimulus engines onto
//            one shared checker (exact match or inclusive unsigned range),
//            keeps saturating test/fail counts, raises a sticky pass/fail
//            verdict at end of run, and forces a fail via a watchdog if the
//            run never completes.
// Ports    :
//   clk            - rising-edge clock
//   rst_n          - asynchronous active-low reset
//   i_req          - per-requester compare request
//   i_mode         - per-requester mode: 0 = equality, 1 = range
//   i_min_val      - expected value / range minimum, packed per requester
//   i_max_val      - range maximum, packed per requester
//   i_measured     - measured value, packed per requester
//   i_all_done     - single-cycle end-of-run pulse
//   o_gnt          - one-hot grant, one cycle
//   o_result_valid - one-cycle result strobe
//   o_result_pass  - verdict of the reported check
//   o_result_id    - requester index of the reported check
//   o_test_count   - completed checks (saturating)
//   o_fail_count   - failed checks (saturating)
//   o_test_passed  - sticky run-pass flag
//   o_test_failed  - sticky run-fail flag
//   o_timeout      - sticky watchdog flag
// Revision : 1.0 - initial release
// ============================================================================
module test_check_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_TESTS      = 16,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ-1:0]            i_mode,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_min_val,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_max_val,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_measured,
  input  logic                          i_all_done,
  output logic [NUM_REQ-1:0]            o_gnt,
  output logic                          o_result_valid,
  output logic                          o_result_pass,
  output logic [$clog2(NUM_REQ)-1:0]    o_result_id,
  output logic [CNT_W-1:0]              o_test_count,
  output logic [CNT_W-1:0]              o_fail_count,
  output logic                          o_test_passed,
  output logic                          o_test_failed,
  output logic                          o_timeout
);

  localparam int C_ID_W = $clog2(NUM_REQ);
  localparam int C_WD_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [C_WD_W-1:0] C_WD_LAST  = C_WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  C_CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  C_NUM_TST  = CNT_W'(NUM_TESTS);
  localparam logic [C_ID_W-1:0] C_LAST_RST = C_ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_REPORT = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t                  r_state;
  logic [C_ID_W-1:0]       r_last_grant;
  logic                    r_done_pend;
  logic [C_WD_W-1:0]       r_wdog;
  logic                    r_mode;
  logic [DATA_WIDTH-1:0]   r_min;
  logic [DATA_WIDTH-1:0]   r_max;
  logic [DATA_WIDTH-1:0]   r_meas;
  logic [C_ID_W-1:0]       r_id;

  // Unpacked views of the per-requester operand buses.
  logic [DATA_WIDTH-1:0]   w_min_a  [NUM_REQ];
  logic [DATA_WIDTH-1:0]   w_max_a  [NUM_REQ];
  logic [DATA_WIDTH-1:0]   w_meas_a [NUM_REQ];

  logic                    w_any_req;
  logic [C_ID_W-1:0]       w_win;
  logic [C_ID_W-1:0]       w_idx;
  logic [NUM_REQ-1:0]      w_win_onehot;
  logic                    w_pass;
  logic                    w_wdog_hit;
  logic                    w_verdict_ok;

  genvar g;
  generate
    for (g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign w_min_a[g]  = i_min_val[g*DATA_WIDTH +: DATA_WIDTH];
      assign w_max_a[g]  = i_max_val[g*DATA_WIDTH +: DATA_WIDTH];
      assign w_meas_a[g] = i_measured[g*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Round-robin search starting at last_grant+1. The scan runs from the
  // farthest offset to the nearest so the nearest active requester is the
  // last one written and therefore wins.
  always_comb begin
    w_any_req = 1'b0;
    w_win     = '0;
    w_idx     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = C_ID_W'((int'(r_last_grant) + k) % NUM_REQ);
      if (i_req[w_idx]) begin
        w_any_req = 1'b1;
        w_win     = w_idx;
      end
    end
  end

  assign w_win_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;

  // Evaluated on the captured operands, so late operand changes are ignored.
  assign w_pass = r_mode ? ((r_min <= r_meas) && (r_meas <= r_max))
                         : (r_meas == r_min);

  assign w_wdog_hit   = (r_wdog == C_WD_LAST);
  assign w_verdict_ok = (o_test_count == C_NUM_TST) && (o_fail_count == '0)
                        && !o_test_failed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_last_grant   <= C_LAST_RST;
      r_done_pend    <= 1'b0;
      r_wdog         <= '0;
      r_mode         <= 1'b0;
      r_min          <= '0;
      r_max          <= '0;
      r_meas         <= '0;
      r_id           <= '0;
      o_gnt          <= '0;
      o_result_valid <= 1'b0;
      o_result_pass  <= 1'b0;
      o_result_id    <= '0;
      o_test_count   <= '0;
      o_fail_count   <= '0;
      o_test_passed  <= 1'b0;
      o_test_failed  <= 1'b0;
      o_timeout      <= 1'b0;
    end else begin
      // End-of-run request is remembered in every state; IDLE acts on it
      // only once any in-flight check has been reported.
      r_done_pend <= r_done_pend | i_all_done;

      if (r_state != ST_DONE) begin
        r_wdog <= r_wdog + C_WD_W'(1);
      end

      if ((r_state != ST_DONE) && w_wdog_hit) begin
        // Watchdog wins over everything: any in-flight check is dropped.
        r_state        <= ST_DONE;
        o_timeout      <= 1'b1;
        o_test_failed  <= 1'b1;
        o_test_passed  <= 1'b0;
        o_gnt          <= '0;
        o_result_valid <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (r_done_pend) begin
              r_state <= ST_DONE;
              if (w_verdict_ok) begin
                o_test_passed <= 1'b1;
              end else begin
                o_test_failed <= 1'b1;
              end
            end else if (w_any_req) begin
              r_mode       <= i_mode[w_win];
              r_min        <= w_min_a[w_win];
              r_max        <= w_max_a[w_win];
              r_meas       <= w_meas_a[w_win];
              r_id         <= w_win;
              r_last_grant <= w_win;
              o_gnt        <= w_win_onehot;
              r_state      <= ST_CHECK;
            end
          end

          ST_CHECK: begin
            if (o_test_count != C_CNT_MAX) begin
              o_test_count <= o_test_count + CNT_W'(1);
            end
            if (!w_pass) begin
              if (o_fail_count != C_CNT_MAX) begin
                o_fail_count <= o_fail_count + CNT_W'(1);
              end
              o_test_failed <= 1'b1;
            end
            o_result_valid <= 1'b1;
            o_result_pass  <= w_pass;
            o_result_id    <= r_id;
            o_gnt          <= '0;
            r_state        <= ST_REPORT;
          end

          ST_REPORT: begin
            o_result_valid <= 1'b0;
            r_state        <= ST_IDLE;
          end

          ST_DONE: begin
            o_gnt          <= '0;
            o_result_valid <= 1'b0;
          end

          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_test_check_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_test_check_arbiter
// Purpose  : Self-checking bench for test_check_arbiter. Expected results are
//            queued when a request is driven and compared when the DUT
//            strobes result_valid. A second instance with a short watchdog
//            limit exercises the timeout path.
// Revision : 1.0 - initial release
// ============================================================================
module tb_test_check_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           rst_n_wd = 1'b0;
  logic [NR-1:0]  req = '0;
  logic [NR-1:0]  mode = '0;
  logic [NR*DW-1:0] minv = '0;
  logic [NR*DW-1:0] maxv = '0;
  logic [NR*DW-1:0] meas = '0;
  logic           all_done = 1'b0;
  logic           wd_all_done = 1'b0;

  logic [NR-1:0]  o_gnt;
  logic           o_rv, o_rp;
  logic [1:0]     o_rid;
  logic [15:0]    o_tc, o_fc;
  logic           o_tp, o_tf, o_to;

  logic [NR-1:0]  wd_gnt;
  logic           wd_rv, wd_rp;
  logic [1:0]     wd_rid;
  logic [15:0]    wd_tc, wd_fc;
  logic           wd_tp, wd_tf, wd_to;

  always #5 clk = ~clk;

  test_check_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .NUM_TESTS(16), .CNT_W(16),
    .TIMEOUT_CYCLES(1000000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_req(req), .i_mode(mode),
    .i_min_val(minv), .i_max_val(maxv), .i_measured(meas),
    .i_all_done(all_done), .o_gnt(o_gnt), .o_result_valid(o_rv),
    .o_result_pass(o_rp), .o_result_id(o_rid), .o_test_count(o_tc),
    .o_fail_count(o_fc), .o_test_passed(o_tp), .o_test_failed(o_tf),
    .o_timeout(o_to)
  );

  test_check_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .NUM_TESTS(16), .CNT_W(16),
    .TIMEOUT_CYCLES(50)
  ) dut_wd (
    .clk(clk), .rst_n(rst_n_wd), .i_req(req), .i_mode(mode),
    .i_min_val(minv), .i_max_val(maxv), .i_measured(meas),
    .i_all_done(wd_all_done), .o_gnt(wd_gnt), .o_result_valid(wd_rv),
    .o_result_pass(wd_rp), .o_result_id(wd_rid), .o_test_count(wd_tc),
    .o_fail_count(wd_fc), .o_test_passed(wd_tp), .o_test_failed(wd_tf),
    .o_timeout(wd_to)
  );

  typedef struct {
    logic [1:0]  id;
    logic        pass;
    logic [15:0] tc;
    logic [15:0] fc;
    logic        tf;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_tc = 0;
  int   m_fc = 0;
  logic m_tf = 1'b0;

  task automatic chk_eq(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int id, input logic pass);
    exp_t e;
    m_tc++;
    if (!pass) begin
      m_fc++;
      m_tf = 1'b1;
    end
    e.id   = id[1:0];
    e.pass = pass;
    e.tc   = m_tc[15:0];
    e.fc   = m_fc[15:0];
    e.tf   = m_tf;
    sb_q.push_back(e);
  endtask

  // Scoreboard consumer.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (rst_n && o_rv) begin
      if (sb_q.size() == 0) begin
        chk_eq("unexpected_result", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk_eq("result_id",   o_rid, e.id);
        chk_eq("result_pass", o_rp,  e.pass);
        chk_eq("test_count",  o_tc,  e.tc);
        chk_eq("fail_count",  o_fc,  e.fc);
        chk_eq("test_failed", o_tf,  e.tf);
      end
    end
  end

  task automatic set_op(input int id, input logic md, input logic [31:0] mn,
                        input logic [31:0] mx, input logic [31:0] ms);
    mode[id]          = md;
    minv[id*DW +: DW] = mn;
    maxv[id*DW +: DW] = mx;
    meas[id*DW +: DW] = ms;
  endtask

  task automatic do_reset(input bit check_vals);
    rst_n    = 1'b0;
    req      = '0;
    all_done = 1'b0;
    sb_q.delete();
    m_tc = 0;
    m_fc = 0;
    m_tf = 1'b0;
    #1;
    if (check_vals) begin
      chk_eq("rst_gnt", o_gnt, 0);
      chk_eq("rst_rv",  o_rv,  0);
      chk_eq("rst_rp",  o_rp,  0);
      chk_eq("rst_rid", o_rid, 0);
      chk_eq("rst_tc",  o_tc,  0);
      chk_eq("rst_fc",  o_fc,  0);
      chk_eq("rst_tp",  o_tp,  0);
      chk_eq("rst_tf",  o_tf,  0);
      chk_eq("rst_to",  o_to,  0);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Entered and left at one step after a rising edge with the DUT in IDLE.
  task automatic do_check(input int id, input logic md, input logic [31:0] mn,
                          input logic [31:0] mx, input logic [31:0] ms,
                          input bit with_done);
    logic p;
    p = md ? ((mn <= ms) && (ms <= mx)) : (ms == mn);
    set_op(id, md, mn, mx, ms);
    req      = 4'b0001 << id;
    all_done = with_done;
    push_exp(id, p);
    @(posedge clk);
    #1;
    all_done = 1'b0;
    req      = '0;
    chk_eq("gnt", o_gnt, 4'b0001 << id);
    // Operands move after capture; the result must not follow them.
    set_op(id, ~md, ~mn, ~mx, ~ms);
    @(posedge clk);
    #1;
    chk_eq("gnt_clear", o_gnt, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic finish_run();
    all_done = 1'b1;
    @(posedge clk);
    #1;
    all_done = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Sequential equality checks, then a passing verdict.
    do_reset(1'b1);
    for (int i = 0; i < 16; i++) do_check(0, 1'b0, 32'hA5, 32'h0, 32'hA5, 1'b0);
    finish_run();
    chk_eq("seq_passed", o_tp, 1);
    chk_eq("seq_failed", o_tf, 0);
    chk_eq("seq_tc", o_tc, 16);
    chk_eq("seq_fc", o_fc, 0);
    req = 4'hF;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk_eq("done_no_gnt", o_gnt, 0);
    end
    req = '0;

    // Range boundaries on requester 2.
    do_reset(1'b0);
    do_check(2, 1'b1, 32'h10, 32'h20, 32'h10, 1'b0);
    do_check(2, 1'b1, 32'h10, 32'h20, 32'h20, 1'b0);
    do_check(2, 1'b1, 32'h10, 32'h20, 32'h21, 1'b0);
    chk_eq("range_fc", o_fc, 1);
    chk_eq("range_tf", o_tf, 1);
    chk_eq("range_tp", o_tp, 0);

    // Round robin with every request held.
    do_reset(1'b0);
    for (int i = 0; i < NR; i++) set_op(i, 1'b0, i, 0, (i == 3) ? 32'h99 : i);
    req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk_eq("rr_gnt", o_gnt, 4'b0001 << (k % NR));
      push_exp(k % NR, (k % NR) != 3);
      @(posedge clk);
      #1;
      chk_eq("rr_gap", o_gnt, 0);
      @(posedge clk);
    end
    #1;
    req = '0;
    @(posedge clk);
    #1;
    chk_eq("rr_stop", o_gnt, 0);

    // Fifteen passing checks is not enough.
    do_reset(1'b0);
    for (int i = 0; i < 15; i++) do_check(1, 1'b0, 32'h5A5A, 32'h0, 32'h5A5A, 1'b0);
    finish_run();
    chk_eq("short_tf", o_tf, 1);
    chk_eq("short_tp", o_tp, 0);
    chk_eq("short_tc", o_tc, 15);

    // End-of-run pulse on the edge that captures the 16th check.
    do_reset(1'b0);
    for (int i = 0; i < 15; i++) do_check(0, 1'b0, 32'h1, 32'h0, 32'h1, 1'b0);
    do_check(0, 1'b0, 32'h1, 32'h0, 32'h1, 1'b1);
    chk_eq("late_tp_wait", o_tp, 0);
    @(posedge clk);
    #1;
    chk_eq("late_tp", o_tp, 1);
    chk_eq("late_tf", o_tf, 0);
    chk_eq("late_tc", o_tc, 16);

    // Reset mid-check clears everything at once.
    set_op(0, 1'b0, 32'h7, 32'h0, 32'h7);
    req = 4'b0001;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_eq("pre_rst_gnt", o_gnt, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_eq("async_gnt", o_gnt, 0);
    chk_eq("async_tc", o_tc, 0);
    chk_eq("async_tp", o_tp, 0);
    chk_eq("async_rv", o_rv, 0);
    sb_q.delete();
    req = '0;

    // Watchdog instance, main DUT held in reset.
    for (int i = 0; i < NR; i++) set_op(i, 1'b0, 32'h3, 32'h0, 32'h3);
    req = 4'hF;
    rst_n_wd = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n_wd = 1'b1;
    repeat (49) @(posedge clk);
    #1;
    chk_eq("wd_before", wd_to, 0);
    @(posedge clk);
    #1;
    chk_eq("wd_timeout", wd_to, 1);
    chk_eq("wd_tf", wd_tf, 1);
    chk_eq("wd_tp", wd_tp, 0);
    chk_eq("wd_tc_dropped", wd_tc, 16);
    chk_eq("wd_rv", wd_rv, 0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk_eq("wd_no_gnt", wd_gnt, 0);
    end
    #2;
    rst_n_wd = 1'b0;
    #1;
    chk_eq("wd_rst_to", wd_to, 0);
    chk_eq("wd_rst_tf", wd_tf, 0);
    chk_eq("wd_rst_tc", wd_tc, 0);
    req = '0;

    chk_eq("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
